pic_ram_wr_arb: RTL
===================

PIC_RAM_WR_ARB -- requirements
Module: pic_ram_wr_arb

Interface
REQ-001 Parameter ADDR_W, default 15, width of picture-RAM write address.
REQ-002 Parameter DATA_W, default 16, width of picture-RAM write data.
REQ-003 Parameter BURST_MAX, default 16, max write beats per grant (range 1..256).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req0 / i_req1  in  1  requester 0 (mp3 buffer writer) / requester 1 (image loader) write request.
REQ-007 i_addr0 / i_addr1  in  ADDR_W  write address from requester 0 / 1.
REQ-008 i_data0 / i_data1  in  DATA_W  write data from requester 0 / 1.
REQ-009 i_last0 / i_last1  in  1  final beat of current burst, sampled with a beat.
REQ-010 o_gnt0 / o_gnt1  out  1  grant; a beat is accepted each cycle gnt and req both high.
REQ-011 o_wea  out  1  RAM write enable.
REQ-012 o_addra  out  ADDR_W  RAM write address.
REQ-013 o_dina  out  DATA_W  RAM write data.
REQ-014 o_owner  out  1  index of requester last granted.
REQ-015 o_busy  out  1  high while any grant is active.

Function
REQ-016 State machine SHALL have states IDLE, GNT0, GNT1, GAP; all outputs registered.
REQ-017 IDLE: any req high -> move to GNT0 or GNT1 per REQ-022/REQ-023; o_gntX asserts the cycle after req first seen (1-cycle grant latency).
REQ-018 In GNTx, each cycle with i_reqx=1 SHALL be one beat: o_wea=1, o_addra/o_dina = that beat's addr/data, one cycle later (1-cycle write latency).
REQ-019 Cycles in GNTx with i_reqx=0 SHALL release the grant: no write, go to GAP.
REQ-020 Beat counter (8 bits) SHALL clear on grant entry, increment per beat; grant releases after the beat where i_lastx=1 or count reaches BURST_MAX, whichever first.
REQ-021 GAP: one dead cycle, gnt low, o_wea low next cycle, then IDLE; guarantees a requester cannot hold the RAM more than BURST_MAX+2 cycles while the other waits.
REQ-022 Both req high in IDLE: winner per REQ-033.
REQ-023 Single req high in IDLE: that requester wins regardless of history.
REQ-024 o_gnt0 and o_gnt1 SHALL never be high simultaneously; o_busy = o_gnt0|o_gnt1.
REQ-025 o_owner SHALL update on grant entry and hold through IDLE/GAP.
REQ-026 Non-granted requester's addr/data/last SHALL be ignored; o_addra/o_dina hold last value when o_wea=0.
REQ-027 i_lastx with BURST_MAX already reached SHALL cause a single release, not two.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, o_gnt0=o_gnt1=0, o_wea=0, o_addra=0, o_dina=0, o_busy=0, o_owner=1, beat counter 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no further write; first arbitration after release grants requester 0 if both request.
REQ-030 Reset release SHALL take effect on first clk rising edge after rst_n high; no write occurs in that cycle.

Configuration
REQ-031 Macro PIC_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-032 Without macro: fixed priority, requester 0 always wins contention.
REQ-033 With macro: round robin, contention won by requester != o_owner.

Verification
REQ-034 Req0 alone, 4 beats addr 0x0010..0x0013 data 0xA000..0xA003, last on 4th -> gnt0 one cycle after req, four o_wea pulses matching addr/data one cycle late, GAP, busy low.
REQ-035 Req0 held 20 beats with no last, BURST_MAX=16 -> exactly 16 writes, release, GAP, re-grant to req0 if req1 idle.
REQ-036 Both req held continuously, macro defined -> grants alternate 0,1,0,1 each burst of 16; undefined -> req0 granted every burst, req1 starved.
REQ-037 Reset pulse during 3rd beat of req1 burst -> o_wea low immediately, no further writes; after release with both req high, gnt0 first.
REQ-038 Req1 drops mid-burst after 5 beats -> 5 writes, grant released, GAP, then IDLE.
REQ-039 Random req/last streams, 10k cycles -> gnt0&gnt1 never both high; o_wea only one cycle after an accepted beat.

Source files
------------

// File: rtl/pic_ram_wr_arb_if.sv
// ---------------------------------------------------------------------------
// pic_ram_wr_arb_if
// Purpose : bundles the two requester write ports and the picture-RAM write
//           port of pic_ram_wr_arb into one interface.
// Signals : i_req0/1, i_addr0/1, i_data0/1, i_last0/1  requester side
//           o_gnt0/1                                    grants back to requesters
//           o_wea, o_addra, o_dina                      RAM write port
//           o_owner, o_busy                             status
// Modports: slave  - the arbiter (consumes i_*, drives o_*)
//           master - the environment (drives i_*, observes o_*)
// ---------------------------------------------------------------------------
interface pic_ram_wr_arb_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              i_req0,  i_req1;
    logic [ADDR_W-1:0] i_addr0, i_addr1;
    logic [DATA_W-1:0] i_data0, i_data1;
    logic              i_last0, i_last1;
    logic              o_gnt0,  o_gnt1;
    logic              o_wea;
    logic [ADDR_W-1:0] o_addra;
    logic [DATA_W-1:0] o_dina;
    logic              o_owner;
    logic              o_busy;

    modport slave (
        input  i_req0, i_req1, i_addr0, i_addr1, i_data0, i_data1, i_last0, i_last1,
        output o_gnt0, o_gnt1, o_wea, o_addra, o_dina, o_owner, o_busy
    );

    modport master (
        output i_req0, i_req1, i_addr0, i_addr1, i_data0, i_data1, i_last0, i_last1,
        input  o_gnt0, o_gnt1, o_wea, o_addra, o_dina, o_owner, o_busy
    );
endinterface

// File: rtl/pic_ram_wr_arb.sv
// ---------------------------------------------------------------------------
// pic_ram_wr_arb
// Purpose : arbitrates picture-RAM write access between requester 0 (mp3
//           buffer writer) and requester 1 (image loader). A grant lasts
//           until the requester drops req, flags last, or BURST_MAX beats
//           have been written; a dead GAP cycle then follows before the next
//           arbitration. All outputs are registered.
// Ports   : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           bus    - pic_ram_wr_arb_if.slave (requests, grants, RAM port)
// Config  : PIC_ARB_ROUND_ROBIN_EN defined   -> contention goes to the
//           requester that is not o_owner (round robin).
//           PIC_ARB_ROUND_ROBIN_EN undefined -> requester 0 always wins
//           contention (fixed priority).
// ---------------------------------------------------------------------------
module pic_ram_wr_arb #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pic_ram_wr_arb_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [8:0] C_MAX = 9'(BURST_MAX);

    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_gnt0, r_gnt1, r_wea, r_owner, r_busy;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dina;

    logic              w_in_gnt, w_req_cur, w_last_cur, w_beat, w_end, w_pick1;
    logic [ADDR_W-1:0] w_addr_cur;
    logic [DATA_W-1:0] w_data_cur;
    logic [8:0]        w_cnt_nxt;

    // Only the granted requester's signals are ever looked at.
    assign w_in_gnt   = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_req_cur  = (r_state == S_GNT1) ? bus.i_req1  : bus.i_req0;
    assign w_last_cur = (r_state == S_GNT1) ? bus.i_last1 : bus.i_last0;
    assign w_addr_cur = (r_state == S_GNT1) ? bus.i_addr1 : bus.i_addr0;
    assign w_data_cur = (r_state == S_GNT1) ? bus.i_data1 : bus.i_data0;

    assign w_beat    = w_in_gnt & w_req_cur;
    // 9-bit count so BURST_MAX=256 is reachable with an 8-bit counter.
    assign w_cnt_nxt = {1'b0, r_cnt} + 9'd1;
    // last and max-count collapse into one release condition.
    assign w_end     = w_beat & (w_last_cur | (w_cnt_nxt == C_MAX));

`ifdef PIC_ARB_ROUND_ROBIN_EN
    // Under contention the requester that did not own the RAM last wins.
    assign w_pick1 = bus.i_req1 & (~bus.i_req0 | ~r_owner);
`else
    assign w_pick1 = bus.i_req1 & ~bus.i_req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
            r_owner <= 1'b1;   // makes requester 0 the first round-robin winner
        end else begin
            r_wea <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_req0 | bus.i_req1) begin
                        r_state <= w_pick1 ? S_GNT1 : S_GNT0;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_busy  <= 1'b1;
                        r_owner <= w_pick1;
                        r_cnt   <= 8'd0;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (w_beat) begin
                        r_wea   <= 1'b1;
                        r_addra <= w_addr_cur;
                        r_dina  <= w_data_cur;
                        r_cnt   <= w_cnt_nxt[7:0];
                    end
                    if (!w_req_cur || w_end) begin
                        r_state <= S_GAP;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;   // S_GAP: one dead cycle
            endcase
        end
    end

    assign bus.o_gnt0  = r_gnt0;
    assign bus.o_gnt1  = r_gnt1;
    assign bus.o_busy  = r_busy;
    assign bus.o_wea   = r_wea;
    assign bus.o_addra = r_addra;
    assign bus.o_dina  = r_dina;
    assign bus.o_owner = r_owner;

endmodule
